mem_ctrl: RTL and testbench
===========================

MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameter MEM_SIZE, default 1024, SHALL be the memory depth in 32-bit words.
REQ-002 Parameter LATENCY, default 1, range 0..15, SHALL be the wait cycles inserted between request acceptance and memory access.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 req_valid  input  1  SHALL mean a request is presented.
REQ-006 req_ready  output  1  SHALL mean a request can be accepted this cycle.
REQ-007 req_we  input  1  SHALL select write (1) or read (0).
REQ-008 req_addr  input  32  SHALL be the byte address.
REQ-009 req_size  input  2  SHALL encode the access size: 00 byte, 01 half, 10 word; 11 is reserved and returns an error.
REQ-010 req_unsigned  input  1  SHALL select zero-extension (1) or sign-extension (0) of sub-word reads.
REQ-011 req_wdata  input  32  SHALL be the write data, taken from its low bytes for sub-word writes.
REQ-012 resp_valid  output  1  SHALL pulse for one cycle when the access completes.
REQ-013 resp_rdata  output  32  SHALL be the extended read data, and 0 for writes and errors.
REQ-014 resp_err  output  1  SHALL flag an erroneous access and is valid with resp_valid.
REQ-015 busy  output  1  SHALL be high in every state except IDLE.

Function
REQ-016 The FSM SHALL have states IDLE, WAIT and ACCESS.
- IDLE -> WAIT on handshake when LATENCY > 0.
- IDLE -> ACCESS on handshake when LATENCY = 0.
- WAIT -> ACCESS when the wait counter reaches LATENCY-1.
- ACCESS -> IDLE unconditionally.
REQ-017 req_ready SHALL be high only in IDLE; handshake = req_valid && req_ready.
REQ-018 On handshake the block SHALL latch we, addr, size, unsigned and wdata; input changes after that SHALL have no effect on the access.
REQ-019 resp_valid SHALL assert exactly LATENCY+1 cycles after the handshake edge, for one cycle, with no back-pressure.
REQ-020 Word index SHALL be addr[ADDR_W+1:2], where ADDR_W = $clog2(MEM_SIZE).
- Byte lane = addr[1:0].
- Half lane = addr[1].
REQ-021 Read data:
- Byte/half SHALL be extracted from the selected lane.
- Extension SHALL be sign or zero per the latched req_unsigned.
- Word reads SHALL be returned unmodified.
REQ-022 Writes SHALL modify only the addressed bytes; the other bytes of the word are preserved.
- The write SHALL commit on the ACCESS->IDLE edge.
REQ-023 Any of the following SHALL set resp_err=1, suppress the write and give resp_rdata=0:
- word index >= MEM_SIZE;
- req_size=11.
REQ-024 A new request SHALL be accepted no earlier than the cycle after resp_valid.
- Back-to-back throughput is one access per LATENCY+2 cycles.
REQ-025 Memory contents SHALL be uninitialised and SHALL NOT be affected by reset.

Reset
REQ-026 While reset=0:
- state = IDLE, wait counter = 0;
- resp_valid = 0, resp_rdata = 0, resp_err = 0, busy = 0;
- req_ready = 1.
REQ-027 Reset asserted during WAIT or ACCESS SHALL abort the access; no memory byte is modified.
REQ-028 The first handshake SHALL be possible on the first rising edge after reset deasserts.

Configuration
REQ-029 Macro MEM_CTRL_MISALIGN_CHECK_EN defined: half access with addr[0]=1, or word access with addr[1:0]!=0, SHALL return resp_err=1 with no write.
REQ-030 Macro MEM_CTRL_MISALIGN_CHECK_EN undefined: low address bits SHALL be forced aligned to the access size (half clears bit 0, word clears bits 1:0), and no misalignment error is raised.

Verification
REQ-031 LATENCY=1: write word 0xDEADBEEF @0x10, then read word @0x10 -> resp_valid 2 cycles after each handshake, rdata=0xDEADBEEF, err=0.
REQ-032 After REQ-031: write byte 0x5A @0x12, then read word @0x10 -> 0xDE5ABEEF; read byte signed @0x13 -> 0xFFFFFFDE; read half unsigned @0x12 -> 0x0000DE5A.
REQ-033 MEM_SIZE=1024: read word @0x1000 -> err=1, rdata=0; write @0x1000 leaves word 0 unchanged.
REQ-034 Macro defined: read word @0x11 -> err=1. Macro undefined: same read returns the word at @0x10.
REQ-035 LATENCY=3: write word 0x12345678 @0x20, reset pulsed low during WAIT; re-read @0x20 -> prior value.
- Also check req_ready=1 and busy=0 during reset.
REQ-036 LATENCY=0: req_valid held high with reads @0x0, 0x4, 0x8 -> handshakes 2 cycles apart, resp_valid one cycle after each.

Source files
------------

// File: rtl/mem_ctrl_if.sv
// rtl/mem_ctrl_if.sv - request/response bus between a requester and mem_ctrl.
interface mem_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - single-port word memory with byte/half/word access and fixed wait latency.
// Optional MEM_CTRL_MISALIGN_CHECK_EN: misaligned half/word accesses return an error instead of being aligned.
module mem_ctrl #(
  parameter int MEM_SIZE = 1024,
  parameter int LATENCY  = 1
) (
  input  logic       clk,
  input  logic       reset,
  mem_ctrl_if.slave  bus,
  output logic       busy
);

  localparam int ADDR_W = $clog2(MEM_SIZE);
  localparam logic [3:0] LAST_WAIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS} state_t;

  state_t      state, next_state;
  logic [3:0]  cnt;
  logic        hs;

  logic        lat_we;
  logic [31:0] lat_addr;
  logic [1:0]  lat_size;
  logic        lat_unsigned;
  logic [31:0] lat_wdata;

  logic [31:0] mem [MEM_SIZE];
  logic [ADDR_W-1:0] widx;
  logic [31:0] word;
  logic [1:0]  lane;
  logic        mis;
  logic        range_err;
  logic        err;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] rd;
  logic [3:0]  wbe;
  logic [31:0] wword;

  assign hs = bus.req_valid && bus.req_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (hs) next_state = (LATENCY == 0) ? S_ACCESS : S_WAIT;
      S_WAIT:   if (cnt == LAST_WAIT) next_state = S_ACCESS;
      S_ACCESS: next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = (state == S_IDLE);
    busy          = (state != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= 4'd0;
    end else if (state == S_WAIT && next_state == S_WAIT) begin
      cnt <= cnt + 4'd1;
    end else begin
      cnt <= 4'd0;
    end
  end

  // Request fields are captured once so the requester may change them freely afterwards.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lat_we       <= 1'b0;
      lat_addr     <= 32'd0;
      lat_size     <= 2'd0;
      lat_unsigned <= 1'b0;
      lat_wdata    <= 32'd0;
    end else if (hs) begin
      lat_we       <= bus.req_we;
      lat_addr     <= bus.req_addr;
      lat_size     <= bus.req_size;
      lat_unsigned <= bus.req_unsigned;
      lat_wdata    <= bus.req_wdata;
    end
  end

  always_comb begin
    case (lat_size)
      2'b01:   lane = {lat_addr[1], 1'b0};
      2'b10:   lane = 2'b00;
      default: lane = lat_addr[1:0];
    endcase
  end

`ifdef MEM_CTRL_MISALIGN_CHECK_EN
  assign mis = (lat_size == 2'b01 && lat_addr[0]) ||
               (lat_size == 2'b10 && lat_addr[1:0] != 2'b00);
`else
  assign mis = 1'b0;
`endif

  // The full upper address is compared so aliases above the memory are rejected.
  assign range_err = ({2'b00, lat_addr[31:2]} >= 32'(MEM_SIZE));
  assign err       = range_err || (lat_size == 2'b11) || mis;
  assign widx      = lat_addr[ADDR_W+1:2];
  assign word      = mem[widx];

  always_comb begin
    byte_v = word[{lane, 3'b000} +: 8];
    half_v = lane[1] ? word[31:16] : word[15:0];
    case (lat_size)
      2'b00:   rd = lat_unsigned ? {24'd0, byte_v} : {{24{byte_v[7]}}, byte_v};
      2'b01:   rd = lat_unsigned ? {16'd0, half_v} : {{16{half_v[15]}}, half_v};
      default: rd = word;
    endcase
  end

  always_comb begin
    case (lat_size)
      2'b00: begin
        wbe   = 4'b0001 << lane;
        wword = {4{lat_wdata[7:0]}};
      end
      2'b01: begin
        wbe   = lane[1] ? 4'b1100 : 4'b0011;
        wword = {2{lat_wdata[15:0]}};
      end
      default: begin
        wbe   = 4'b1111;
        wword = lat_wdata;
      end
    endcase
  end

  // Reset forces state to IDLE asynchronously, so an aborted access never reaches this write.
  always_ff @(posedge clk) begin
    if (state == S_ACCESS && lat_we && !err) begin
      for (int i = 0; i < 4; i++) begin
        if (wbe[i]) mem[widx][8*i +: 8] <= wword[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.resp_valid <= 1'b0;
      bus.resp_err   <= 1'b0;
      bus.resp_rdata <= 32'd0;
    end else begin
      bus.resp_valid <= (state == S_ACCESS);
      bus.resp_err   <= (state == S_ACCESS) && err;
      bus.resp_rdata <= (state == S_ACCESS && !err && !lat_we) ? rd : 32'd0;
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - self-checking bench for mem_ctrl at LATENCY 0, 1 and 3.
module tb_mem_ctrl;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        valid, we, uns;
  logic [31:0] addr, wdata;
  logic [1:0]  size;
  int          sel;
  int          cyc = 0;
  int          n_pass = 0;
  int          n_total = 0;

  exp_t sb[$];
  exp_t e_mon;
  vec_t tbl[$];

  logic busy0, busy1, busy3;
  logic ready_m, busy_m, rv_m, err_m;
  logic [31:0] rd_m;

  mem_ctrl_if b0 ();
  mem_ctrl_if b1 ();
  mem_ctrl_if b3 ();

  assign b0.req_valid = valid && (sel == 0);
  assign b1.req_valid = valid && (sel == 1);
  assign b3.req_valid = valid && (sel == 2);
  assign b0.req_we = we;      assign b1.req_we = we;      assign b3.req_we = we;
  assign b0.req_addr = addr;  assign b1.req_addr = addr;  assign b3.req_addr = addr;
  assign b0.req_size = size;  assign b1.req_size = size;  assign b3.req_size = size;
  assign b0.req_unsigned = uns; assign b1.req_unsigned = uns; assign b3.req_unsigned = uns;
  assign b0.req_wdata = wdata; assign b1.req_wdata = wdata; assign b3.req_wdata = wdata;

  mem_ctrl #(.MEM_SIZE(1024), .LATENCY(0)) dut0 (.clk(clk), .reset(rst_n), .bus(b0), .busy(busy0));
  mem_ctrl #(.MEM_SIZE(1024), .LATENCY(1)) dut1 (.clk(clk), .reset(rst_n), .bus(b1), .busy(busy1));
  mem_ctrl #(.MEM_SIZE(1024), .LATENCY(3)) dut3 (.clk(clk), .reset(rst_n), .bus(b3), .busy(busy3));

  always_comb begin
    case (sel)
      0: begin ready_m = b0.req_ready; busy_m = busy0; rv_m = b0.resp_valid; rd_m = b0.resp_rdata; err_m = b0.resp_err; end
      1: begin ready_m = b1.req_ready; busy_m = busy1; rv_m = b1.resp_valid; rd_m = b1.resp_rdata; err_m = b1.resp_err; end
      default: begin ready_m = b3.req_ready; busy_m = busy3; rv_m = b3.resp_valid; rd_m = b3.resp_rdata; err_m = b3.resp_err; end
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  function automatic int lat_of(input int s);
    return (s == 0) ? 0 : (s == 1) ? 1 : 3;
  endfunction

  // Scoreboard: every response must match the oldest outstanding expectation and arrive LATENCY+1 edges after its handshake.
  always @(negedge clk) begin
    if (rv_m) begin
      if (sb.size() == 0) begin
        check("unexpected_resp", 32'd1, 32'd0);
      end else begin
        e_mon = sb.pop_front();
        check("rdata", rd_m, e_mon.rdata);
        check("err", {31'd0, err_m}, {31'd0, e_mon.err});
        check("latency", cyc, e_mon.cyc + lat_of(sel) + 1);
        check("busy_at_resp", {31'd0, busy_m}, 32'd0);
      end
    end
  end

  task automatic drive(input vec_t v);
    we = v.we; addr = v.addr; size = v.size; uns = v.uns; wdata = v.wdata;
  endtask

  task automatic do_req(input vec_t v);
    int guard;
    @(negedge clk);
    drive(v);
    valid = 1'b1;
    guard = 0;
    while (!ready_m && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("hs_timeout", {31'd0, ready_m}, 32'd1);
    if (ready_m) begin
      sb.push_back('{v.exp_rdata, v.exp_err, cyc + 1});
      @(posedge clk);
      #1;
      valid = 1'b0;
      addr = $urandom; wdata = $urandom; size = 2'($urandom); uns = ~uns; we = ~we;
      check("busy_after_hs", {31'd0, busy_m}, 32'd1);
      guard = 0;
      while (sb.size() != 0 && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      check("resp_timeout", sb.size(), 32'd0);
      sb.delete();
    end else begin
      valid = 1'b0;
    end
  endtask

  logic [31:0] l0_data [3];
  int hs_cyc [3];

  initial begin
    int k, guard;
    rst_n = 1'b0; valid = 1'b0; we = 1'b0; addr = 0; size = 0; uns = 0; wdata = 0; sel = 1;

    tbl.push_back('{1'b1, 32'h10,   2'b10, 1'b0, 32'hDEADBEEF, 32'h0,        1'b0});
    tbl.push_back('{1'b0, 32'h10,   2'b10, 1'b0, 32'h0,        32'hDEADBEEF, 1'b0});
    tbl.push_back('{1'b1, 32'h12,   2'b00, 1'b0, 32'h1234565A, 32'h0,        1'b0});
    tbl.push_back('{1'b0, 32'h10,   2'b10, 1'b0, 32'h0,        32'hDE5ABEEF, 1'b0});
    tbl.push_back('{1'b0, 32'h13,   2'b00, 1'b0, 32'h0,        32'hFFFFFFDE, 1'b0});
    tbl.push_back('{1'b0, 32'h12,   2'b01, 1'b1, 32'h0,        32'h0000DE5A, 1'b0});
    tbl.push_back('{1'b0, 32'h12,   2'b01, 1'b0, 32'h0,        32'hFFFFDE5A, 1'b0});
    tbl.push_back('{1'b0, 32'h13,   2'b00, 1'b1, 32'h0,        32'h000000DE, 1'b0});
    tbl.push_back('{1'b0, 32'h11,   2'b00, 1'b0, 32'h0,        32'hFFFFFFBE, 1'b0});
    tbl.push_back('{1'b1, 32'h0,    2'b10, 1'b0, 32'h11223344, 32'h0,        1'b0});
    tbl.push_back('{1'b0, 32'h1000, 2'b10, 1'b0, 32'h0,        32'h0,        1'b1});
    tbl.push_back('{1'b1, 32'h1000, 2'b10, 1'b0, 32'hCAFEF00D, 32'h0,        1'b1});
    tbl.push_back('{1'b0, 32'h0,    2'b10, 1'b0, 32'h0,        32'h11223344, 1'b0});
    tbl.push_back('{1'b0, 32'h10,   2'b11, 1'b0, 32'h0,        32'h0,        1'b1});
    tbl.push_back('{1'b1, 32'h10,   2'b11, 1'b0, 32'hFFFFFFFF, 32'h0,        1'b1});
    tbl.push_back('{1'b0, 32'h10,   2'b10, 1'b0, 32'h0,        32'hDE5ABEEF, 1'b0});
    tbl.push_back('{1'b1, 32'h2,    2'b01, 1'b0, 32'hFFFF9876, 32'h0,        1'b0});
    tbl.push_back('{1'b0, 32'h0,    2'b10, 1'b0, 32'h0,        32'h98763344, 1'b0});
    tbl.push_back('{1'b0, 32'h0,    2'b00, 1'b0, 32'h0,        32'h00000044, 1'b0});
    tbl.push_back('{1'b1, 32'hFFC,  2'b10, 1'b0, 32'hA5A5A5A5, 32'h0,        1'b0});
    tbl.push_back('{1'b0, 32'hFFC,  2'b10, 1'b0, 32'h0,        32'hA5A5A5A5, 1'b0});
`ifdef MEM_CTRL_MISALIGN_CHECK_EN
    tbl.push_back('{1'b0, 32'h11,   2'b10, 1'b0, 32'h0,        32'h0,        1'b1});
    tbl.push_back('{1'b1, 32'h1,    2'b01, 1'b0, 32'h00007777, 32'h0,        1'b1});
    tbl.push_back('{1'b0, 32'h0,    2'b10, 1'b0, 32'h0,        32'h98763344, 1'b0});
`else
    tbl.push_back('{1'b0, 32'h11,   2'b10, 1'b0, 32'h0,        32'hDE5ABEEF, 1'b0});
    tbl.push_back('{1'b1, 32'h1,    2'b01, 1'b0, 32'h00007777, 32'h0,        1'b0});
    tbl.push_back('{1'b0, 32'h0,    2'b10, 1'b0, 32'h0,        32'h98767777, 1'b0});
`endif

    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, ready_m}, 32'd1);
    check("rst_busy", {31'd0, busy_m}, 32'd0);
    check("rst_resp_valid", {31'd0, rv_m}, 32'd0);
    check("rst_rdata", rd_m, 32'd0);
    check("rst_err", {31'd0, err_m}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) do_req(tbl[i]);

    // LATENCY=0 with req_valid held high across three reads.
    sel = 0;
    l0_data[0] = 32'hA0A0A0A0; l0_data[1] = 32'hB1B1B1B1; l0_data[2] = 32'hC2C2C2C2;
    for (int i = 0; i < 3; i++) do_req('{1'b1, 32'(4 * i), 2'b10, 1'b0, l0_data[i], 32'h0, 1'b0});
    @(negedge clk);
    we = 1'b0; size = 2'b10; uns = 1'b0; addr = 32'h0; valid = 1'b1;
    k = 0; guard = 0;
    while (k < 3 && guard < 30) begin
      if (ready_m) begin
        sb.push_back('{l0_data[k], 1'b0, cyc + 1});
        hs_cyc[k] = cyc + 1;
        k++;
        @(posedge clk);
        #1;
        if (k < 3) addr = 32'(4 * k);
        else valid = 1'b0;
      end
      @(negedge clk);
      guard++;
    end
    valid = 1'b0;
    check("l0_hs_count", k, 32'd3);
    check("l0_hs_gap1", hs_cyc[1] - hs_cyc[0], 32'd2);
    check("l0_hs_gap2", hs_cyc[2] - hs_cyc[1], 32'd2);
    guard = 0;
    while (sb.size() != 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("l0_drain", sb.size(), 32'd0);
    sb.delete();

    // LATENCY=3: reset during WAIT must abort the write.
    sel = 2;
    do_req('{1'b1, 32'h20, 2'b10, 1'b0, 32'hCAFEBABE, 32'h0, 1'b0});
    do_req('{1'b0, 32'h20, 2'b10, 1'b0, 32'h0, 32'hCAFEBABE, 1'b0});
    @(negedge clk);
    drive('{1'b1, 32'h20, 2'b10, 1'b0, 32'h12345678, 32'h0, 1'b0});
    valid = 1'b1;
    @(posedge clk);
    #1;
    valid = 1'b0;
    check("l3_busy_wait", {31'd0, busy_m}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("l3_rst_ready", {31'd0, ready_m}, 32'd1);
    check("l3_rst_busy", {31'd0, busy_m}, 32'd0);
    check("l3_rst_resp_valid", {31'd0, rv_m}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("l3_ready_after_rst", {31'd0, ready_m}, 32'd1);
    do_req('{1'b0, 32'h20, 2'b10, 1'b0, 32'h0, 32'hCAFEBABE, 1'b0});

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
